fp_multiplier_param: RTL
========================

# fp_multiplier_param

Parametrised IEEE-754 binary floating-point multiplier, successor to the fixed fp32 multiplier in the co-processor datapath. Operand format is set by exponent and mantissa width parameters; defaults give binary32. Adds four run-time rounding modes and sticky-free per-operation exception flags. Uses the same STB/BUSY handshake as the other arithmetic units, so it drops into the co-processor pipeline unchanged.

## Interface
- EXP_W, 8, exponent field width; legal range 5..11.
- MAN_W, 23, stored mantissa width; legal range 10..52; W = 1+EXP_W+MAN_W.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous and active-low; sampled on posedge clk.
- input_a, input_b  input  W  operands, sampled on the accept edge.
- round_mode  input  2  00 RNE, 01 RTZ, 10 RDN (toward −inf), 11 RUP (toward +inf); sampled on the accept edge.
- mult_input_STB  input  1  operand valid.
- mult_BUSY  output  1  high from the cycle after accept until return to IDLE.
- output_mult  output  W  result; held stable while mult_output_STB=1.
- mult_flags  output  4  [3] NV invalid, [2] OF overflow, [1] UF underflow, [0] NX inexact; valid with the result.
- mult_output_STB  output  1  result valid.
- output_module_BUSY  input  1  downstream stall.

## Operation
- Bias = 2^(EXP_W−1)−1. Internal exponents are signed, EXP_W+2 bits. The significand is MAN_W+1 bits with the hidden bit restored. The product register is 2*(MAN_W+1)+2 bits (significand product ×4).
- States:
  - IDLE → UNPACK on accept.
  - UNPACK → SPECIAL.
  - SPECIAL → PUT_Z for special cases, otherwise → NORM_A.
  - NORM_A: shift one bit per cycle until the hidden bit is set.
  - NORM_B: same as NORM_A, for operand b.
  - MULT_0: sign = a_s^b_s; exponent = a_e+b_e+1; compute product.
  - MULT_1: extract top MAN_W+1 bits, guard, round, sticky (OR of the rest).
  - NORM_1: left shift while the MSB is 0.
  - NORM_2: right shift while exponent < 1−Bias, ORing shifted-out bits into sticky.
  - ROUND → PACK → PUT_Z → IDLE.
- Accept condition: IDLE, mult_BUSY=0 and mult_input_STB=1 at a posedge.
- Special cases are resolved in SPECIAL, with NX/OF/UF = 0:
  - Any NaN operand, or inf×0: canonical quiet NaN (sign 1, exponent all ones, mantissa MSB 1, rest 0). NV=1.
  - inf×finite-nonzero: signed infinity.
  - 0×finite: signed zero.
- Denormal operands: exponent is forced to 1−Bias and the hidden bit is left clear before NORM_A/NORM_B.
- Rounding: increment when any of the following holds. Mantissa all-ones on increment carries into the exponent.
  - RNE: guard & (round|sticky|lsb).
  - RUP: (guard|round|sticky) & !sign.
  - RDN: (guard|round|sticky) & sign.
  - RTZ: never increments.
- NX = guard|round|sticky, before rounding.
- UF = NX & (pre-rounding exponent < 1−Bias, unbounded).
- Overflow (exponent > Bias after rounding) sets OF=1 and NX=1. The result depends on mode:
  - RNE: ±inf.
  - RTZ: ±max finite.
  - RUP: +inf if positive, −max finite if negative.
  - RDN: −inf if negative, +max finite if positive.
- A denormal or zero result packs exponent field 0.
- PUT_Z drives mult_output_STB=1 and loads output_mult/mult_flags. On an edge where mult_output_STB=1 and output_module_BUSY=0, the result is consumed: STB drops and the state returns to IDLE.

## Timing
- Reset (rst=0 at posedge) has priority over all state logic, including mid-operation.
  - State → IDLE; mult_BUSY=0, mult_output_STB=0, output_mult=0, mult_flags=0.
  - An in-flight operation is discarded with no output.
- Inputs asserted while mult_BUSY=1 or outside IDLE are ignored.
- Latency is counted from the accept edge to the first cycle with mult_output_STB=1:
  - Special case: 3 cycles.
  - Normal×normal, product ≥2: 11 cycles; product <2: 12 cycles.
  - Each denormal-normalisation shift or underflow right-shift adds 1 cycle.
- Backpressure: STB stays high and output_mult/mult_flags stay unchanged for any number of cycles with output_module_BUSY=1.
- Minimum issue interval is latency + 2 cycles: the consume edge enters IDLE, and the next edge may accept.

## Configuration
- FP_MULT_FLAGS_EN defined: mult_flags computed as above.
- Not defined: mult_flags is tied to 4'b0 and all flag logic is removed. Results and timing are identical.

## Test plan
- Default params, RNE: 0x3FC00000×0x3FC00000 → 0x40100000, flags 0, STB 11 cycles after accept. 0x3F800000×0x3F800000 → 0x3F800000 at 12 cycles.
- 0x7F800000×0x00000000 → 0xFFC00000, NV=1, 3 cycles. 0x7FC00001×0x3F800000 → 0xFFC00000, NV=1.
- 0x7F7FFFFF×0x40000000 under each mode:
  - RNE → 0x7F800000, OF=NX=1.
  - RTZ → 0x7F7FFFFF, OF=NX=1.
  - RDN → 0x7F7FFFFF.
  - With a negated operand, RDN → 0xFF800000.
- Subnormals, RNE:
  - 0x00000001×0x3F800000 → 0x00000001, flags 0.
  - 0x00800001×0x3F000000 → 0x00400000, UF=NX=1.
  - Same operands with RUP → 0x00400001.
- Handshake: hold output_module_BUSY=1 for 20 cycles → output stable, STB high. Pulse mult_input_STB while busy → ignored. Assert rst=0 mid-NORM_1 → all outputs 0 next cycle, and no STB follows.
- EXP_W=5, MAN_W=10: 0x3E00×0x3E00 → 0x4080. 0x7BFF×0x4000 RNE → 0x7C00, OF=NX=1.

Source files
------------

// File: rtl/fp_multiplier_param.sv
// Parametrised IEEE-754 binary multiplier with STB/BUSY handshake and four run-time rounding modes.
// Define FP_MULT_FLAGS_EN to compute NV/OF/UF/NX; otherwise mult_flags is tied to zero.
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic [W-1:0] input_b,
  input  logic [1:0]   round_mode,
  input  logic         mult_input_STB,
  output logic         mult_BUSY,
  output logic [W-1:0] output_mult,
  output logic [3:0]   mult_flags,
  output logic         mult_output_STB,
  input  logic         output_module_BUSY
);

  localparam int EW   = EXP_W + 2;
  localparam int SW   = MAN_W + 1;
  localparam int MW   = 2 * SW;
  localparam int PW   = MW + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  typedef logic signed [EW-1:0] exp_t;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rmode_t;

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULT_0,
    MULT_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam exp_t E_BIAS = exp_t'(BIAS);
  localparam exp_t E_MIN  = exp_t'(1 - BIAS);
  localparam exp_t E_ZERO = exp_t'(-BIAS);
  localparam exp_t E_SPEC = exp_t'(BIAS + 1);
  localparam exp_t E_ONE  = exp_t'(1);

  localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t state, state_next;

  logic [W-1:0]  a_raw, b_raw;
  rmode_t        rmode;
  logic          a_s, b_s, z_s;
  exp_t          a_e, b_e, z_e;
  logic [SW-1:0] a_m, b_m, z_m;
  logic [PW-1:0] product;
  logic          guard_bit, round_bit, sticky_bit;

  logic          accept;
  logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic          invalid, special;
  logic [MW-1:0] mul_full;
  logic          inexact, round_up, overflow, to_inf;
  exp_t          biased;
  logic [W-1:0]  special_z, packed_z, result_next;
  logic          load_out;

  assign accept   = (state == IDLE) && !mult_BUSY && mult_input_STB;
  assign load_out = ((state == SPECIAL) && special) || (state == PACK);
  assign mul_full = MW'(a_m) * MW'(b_m);

  always_comb begin
    a_nan   = (a_e == E_SPEC) && (a_m != '0);
    b_nan   = (b_e == E_SPEC) && (b_m != '0);
    a_inf   = (a_e == E_SPEC) && (a_m == '0);
    b_inf   = (b_e == E_SPEC) && (b_m == '0);
    a_zero  = (a_e == E_ZERO) && (a_m == '0);
    b_zero  = (b_e == E_ZERO) && (b_m == '0);
    invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    if (invalid)
      special_z = QNAN;
    else if (a_inf | b_inf)
      special_z = {a_s ^ b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      special_z = {a_s ^ b_s, {(W-1){1'b0}}};
  end

  // Rounding decision and final packing, including the mode-dependent overflow saturation.
  always_comb begin
    inexact = guard_bit | round_bit | sticky_bit;
    case (rmode)
      RM_RNE:  round_up = guard_bit & (round_bit | sticky_bit | z_m[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = inexact & z_s;
      default: round_up = inexact & ~z_s;
    endcase

    case (rmode)
      RM_RNE:  to_inf = 1'b1;
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = z_s;
      default: to_inf = ~z_s;
    endcase

    overflow = z_e > E_BIAS;
    biased   = z_e + E_BIAS;
    if (overflow && to_inf)
      packed_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (overflow)
      packed_z = {z_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    else if ((z_e == E_MIN) && !z_m[MAN_W])
      packed_z = {z_s, {EXP_W{1'b0}}, z_m[MAN_W-1:0]};
    else
      packed_z = {z_s, biased[EXP_W-1:0], z_m[MAN_W-1:0]};

    result_next = (state == PACK) ? packed_z : special_z;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: state_next = special ? PUT_Z : NORM_A;
      NORM_A:  if (a_m[MAN_W]) state_next = NORM_B;
      NORM_B:  if (b_m[MAN_W]) state_next = MULT_0;
      MULT_0:  state_next = MULT_1;
      MULT_1:  state_next = NORM_1;
      NORM_1:  if (z_m[MAN_W]) state_next = NORM_2;
      NORM_2:  if (z_e >= E_MIN) state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = PUT_Z;
      PUT_Z:   if (!output_module_BUSY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      mult_BUSY       <= 1'b0;
      mult_output_STB <= 1'b0;
      output_mult     <= '0;
    end else begin
      state           <= state_next;
      mult_BUSY       <= (state_next != IDLE);
      mult_output_STB <= (state_next == PUT_Z);
      if (load_out) output_mult <= result_next;
    end
  end

  // NOTE: datapath registers carry no reset; each is written before it is read within an operation.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          a_raw <= input_a;
          b_raw <= input_b;
          rmode <= rmode_t'(round_mode);
        end
      end
      UNPACK: begin
        a_s <= a_raw[W-1];
        b_s <= b_raw[W-1];
        a_e <= exp_t'(a_raw[W-2 -: EXP_W]) - E_BIAS;
        b_e <= exp_t'(b_raw[W-2 -: EXP_W]) - E_BIAS;
        a_m <= {1'b0, a_raw[MAN_W-1:0]};
        b_m <= {1'b0, b_raw[MAN_W-1:0]};
      end
      SPECIAL: begin
        // Denormals keep a clear hidden bit at the minimum exponent; normals get it restored.
        if (!special) begin
          if (a_e == E_ZERO) a_e <= E_MIN;
          else               a_m[MAN_W] <= 1'b1;
          if (b_e == E_ZERO) b_e <= E_MIN;
          else               b_m[MAN_W] <= 1'b1;
        end
      end
      NORM_A: begin
        if (!a_m[MAN_W]) begin
          a_m <= a_m << 1;
          a_e <= a_e - E_ONE;
        end
      end
      NORM_B: begin
        if (!b_m[MAN_W]) begin
          b_m <= b_m << 1;
          b_e <= b_e - E_ONE;
        end
      end
      MULT_0: begin
        z_s     <= a_s ^ b_s;
        z_e     <= a_e + b_e + E_ONE;
        product <= {mul_full, 2'b00};
      end
      MULT_1: begin
        z_m        <= product[PW-1 -: SW];
        guard_bit  <= product[PW-SW-1];
        round_bit  <= product[PW-SW-2];
        sticky_bit <= |product[PW-SW-3:0];
      end
      NORM_1: begin
        if (!z_m[MAN_W]) begin
          z_m       <= {z_m[SW-2:0], guard_bit};
          guard_bit <= round_bit;
          round_bit <= 1'b0;
          z_e       <= z_e - E_ONE;
        end
      end
      NORM_2: begin
        if (z_e < E_MIN) begin
          z_e        <= z_e + E_ONE;
          z_m        <= z_m >> 1;
          guard_bit  <= z_m[0];
          round_bit  <= guard_bit;
          sticky_bit <= sticky_bit | round_bit;
        end
      end
      ROUND: begin
        if (round_up) begin
          z_m <= z_m + SW'(1);
          if (&z_m) z_e <= z_e + E_ONE;
        end
      end
      default: ;
    endcase
  end

`ifdef FP_MULT_FLAGS_EN
  logic       tiny, nx_r;
  logic [3:0] flags_next;

  // Tininess is judged on the unbounded exponent, i.e. whenever NORM_2 had to shift.
  always_ff @(posedge clk) begin
    case (state)
      MULT_0:  tiny <= 1'b0;
      NORM_2:  if (z_e < E_MIN) tiny <= 1'b1;
      ROUND:   nx_r <= inexact;
      default: ;
    endcase
  end

  always_comb begin
    flags_next = 4'b0000;
    if (state == PACK)
      flags_next = {1'b0, overflow, nx_r & tiny, nx_r | overflow};
    else
      flags_next = {invalid, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst)          mult_flags <= 4'b0000;
    else if (load_out) mult_flags <= flags_next;
  end
`else
  assign mult_flags = 4'b0000;
`endif

endmodule
